vedic_multiply_seq: RTL and testbench



---
 rtl/vedic_multiply_seq.sv | 128 ++++++++++++
 tb/tb_vedic_multiply_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vedic_multiply_seq.sv
// Multi-cycle Urdhva-Tiryagbhyam (crosswise) unsigned multiplier.
// Evaluates COLS_PER_CYCLE product columns per clock with a chained carry; valid/ready on both sides.
module vedic_multiply_seq #(
    parameter int unsigned RANGE_WIDTH    = 16,
    parameter int unsigned COLS_PER_CYCLE = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [RANGE_WIDTH/2-1:0]   m,
    input  logic [RANGE_WIDTH/2-1:0]   p,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [RANGE_WIDTH-1:0]     r
);

    localparam int unsigned W    = RANGE_WIDTH / 2;
    localparam int unsigned NCOL = 2 * W - 1;
    localparam int unsigned CW   = $clog2(W) + 1;
    localparam int unsigned SW   = CW + 1;
    localparam int unsigned COLW = $clog2(NCOL + COLS_PER_CYCLE) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [W-1:0]           m_q, m_d;
    logic [W-1:0]           p_q, p_d;
    logic [RANGE_WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]          carry_q, carry_d;
    logic [COLW-1:0]        col_q, col_d;

    logic                   accept;
    logic [SW-1:0]          sum;
    logic [CW-1:0]          cy;
    logic [COLW-1:0]        col_k;
    logic [COLW-1:0]        col_next;

    assign in_ready  = reset && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign r         = r_q;
    assign col_next  = col_q + COLW'(COLS_PER_CYCLE);

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        p_d     = p_q;
        r_d     = r_q;
        carry_d = carry_q;
        col_d   = col_q;
        sum     = '0;
        cy      = carry_q;
        col_k   = col_q;

        case (state_q)
            ST_CALC: begin
                // Columns of this cycle are chained: each one consumes the previous column's carry.
                for (int c = 0; c < int'(COLS_PER_CYCLE); c++) begin
                    col_k = col_q + COLW'(c);
                    if (col_k < COLW'(NCOL)) begin
                        sum = SW'(cy);
                        for (int i = 0; i < int'(W); i++) begin
                            for (int j = 0; j < int'(W); j++) begin
                                if (COLW'(i + j) == col_k) begin
                                    sum = sum + SW'(m_q[i] & p_q[j]);
                                end
                            end
                        end
                        for (int b = 0; b < int'(NCOL); b++) begin
                            if (COLW'(b) == col_k) begin
                                r_d[b] = sum[0];
                            end
                        end
                        cy = CW'(sum >> 1);
                    end
                end
                carry_d = cy;
                col_d   = col_next;
                // After the top column the residual carry is at most 1 and becomes the MSB.
                if (col_next >= COLW'(NCOL)) begin
                    r_d[RANGE_WIDTH-1] = cy[0];
                    state_d            = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            m_d     = m;
            p_d     = p;
            r_d     = '0;
            carry_d = '0;
            col_d   = '0;
            state_d = ST_CALC;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            p_q     <= '0;
            r_q     <= '0;
            carry_q <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            p_q     <= p_d;
            r_q     <= r_d;
            carry_q <= carry_d;
            col_q   <= col_d;
        end
    end

endmodule

// File: tb/tb_vedic_multiply_seq.sv
// Directed bench for vedic_multiply_seq: 8x8 (4 cols/cycle) and 16x16 (8 cols/cycle) instances.
module tb_vedic_multiply_seq;

    logic        clk = 1'b0;
    logic        reset;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  m, p;
    logic [15:0] r;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [15:0] b_m, b_p;
    logic [31:0] b_r;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vedic_multiply_seq #(.RANGE_WIDTH(16), .COLS_PER_CYCLE(4)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .m(m), .p(p),
        .out_valid(out_valid), .out_ready(out_ready), .r(r)
    );

    vedic_multiply_seq #(.RANGE_WIDTH(32), .COLS_PER_CYCLE(8)) u_dut32 (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .m(b_m), .p(b_p),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .r(b_r)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction from IDLE on the 8x8 instance, including backpressure and release.
    task automatic do_mul(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        int          n;
        logic [15:0] held;
        check("idle_in_ready", 32'(in_ready), 32'd1);
        m = a; p = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; m = ~a; p = ~b;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check("latency", 32'(n), 32'd4);
        check("product", 32'(r), 32'(exp));
        held = r;
        repeat (2) tick();
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_r", 32'(r), 32'(held));
        check("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_r_kept", 32'(r), 32'(exp));
    endtask

    task automatic do_mul32(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
        int n;
        b_m = a; b_p = b; b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0; b_m = ~a; b_p = ~b;
        n = 0;
        while (!b_out_valid && n < 50) begin
            tick();
            n++;
        end
        check("w16_latency", 32'(n), 32'd4);
        check("w16_product", b_r, exp);
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        check("w16_idle_valid", 32'(b_out_valid), 32'd0);
    endtask

    initial begin
        logic [7:0]  ba [3];
        logic [7:0]  bb [3];
        logic [15:0] be [3];
        logic [7:0]  ra, rb;
        logic        seen;
        int          n, last;

        ba = '{8'h03, 8'hFF, 8'h10};
        bb = '{8'h07, 8'h02, 8'h10};
        be = '{16'h0015, 16'h01FE, 16'h0100};

        reset = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; m = '0; p = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_m = '0; b_p = '0;
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_r", 32'(r), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_w16_valid", 32'(b_out_valid), 32'd0);
        reset = 1'b1;
        tick();

        do_mul(8'hFF, 8'hFF, 16'hFE01);
        do_mul(8'hB7, 8'h5C, 16'h41C4);
        do_mul(8'h00, 8'hAB, 16'h0000);
        do_mul(8'hCD, 8'h00, 16'h0000);
        do_mul(8'h01, 8'hFF, 16'h00FF);
        do_mul(8'h80, 8'h80, 16'h4000);

        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            do_mul(ra, rb, 16'(ra) * 16'(rb));
        end

        // Streaming with DONE->CALC direct accept, then backpressure on the last product.
        out_ready = 1'b1; in_valid = 1'b1; m = ba[0]; p = bb[0];
        tick();
        m = ba[1]; p = bb[1];
        last = 0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!out_valid && n < 50) begin
                tick();
                n++;
            end
            check("b2b_latency", 32'(n), 32'd4);
            check("b2b_product", 32'(r), 32'(be[k]));
            if (k > 0) check("b2b_period", 32'(cyc - last), 32'd5);
            last = cyc;
            if (k < 2) begin
                check("b2b_in_ready", 32'(in_ready), 32'd1);
                tick();
                if (k == 0) begin
                    m = ba[2]; p = bb[2];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        repeat (6) begin
            tick();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_r", 32'(r), 32'h0100);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset lands at the end of the second CALC cycle.
        m = 8'hFF; p = 8'hFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_r", 32'(r), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            tick();
            seen = seen | out_valid;
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        do_mul(8'h12, 8'h34, 16'h03A8);

        do_mul32(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        do_mul32(16'h8000, 16'hFFFF, 32'h7FFF8000);
        do_mul32(16'h1234, 16'h5678, 32'h06260060);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
